// File: rtl/eth_rx_mac.sv
// Ethernet receive front end: preamble/SFD hunt, LSB-first byte assembly,
// CRC-32 residue check, optional FCS stripping and per-frame status.
module eth_rx_mac #(
    parameter int pMII_WIDTH = 2,
    parameter int pMIN_FRAME = 64,
    parameter int pMAX_FRAME = 1518,
    parameter int pSTRIP_FCS = 1
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  Rx_Dv,
    input  logic [pMII_WIDTH-1:0] Rxd,
    input  logic                  Rx_Er,
    output logic                  Byte_Valid,
    output logic [7:0]            Byte,
    output logic                  Byte_Last,
    output logic                  Frame_Done,
    output logic                  Crc_Valid,
    output logic                  Frame_Err,
    output logic [10:0]           Frame_Len,
    output logic                  Rx_Busy
);

    localparam int          LANES       = 8 / pMII_WIDTH;
    localparam logic [1:0]  LANE_LAST   = 2'(LANES - 1);
    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
    localparam logic [10:0] LEN_SAT     = 11'h7FF;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PREAMBLE,
        S_DATA,
        S_DONE
    } state_t;

    function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] b);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            c = (c >> 1) ^ (((c[0] ^ b[i]) == 1'b1) ? 32'hEDB8_8320 : 32'h0);
        end
        return c;
    endfunction

    state_t      state_q, state_d;
    logic [7:0]  sr_q, sr_d;
    logic [1:0]  lane_q, lane_d;
    logic [31:0] crc_q, crc_d;
    logic [10:0] len_q, len_d;
    logic        er_q, er_d;
    logic [7:0]  win_q [4];
    logic [7:0]  win_d [4];
    logic [2:0]  win_cnt_q, win_cnt_d;
    logic [7:0]  held_q, held_d;
    logic        held_vld_q, held_vld_d;

    logic        bv_q, bv_d;
    logic [7:0]  byte_q, byte_d;
    logic        last_q, last_d;
    logic        done_q, done_d;
    logic        crcv_q, crcv_d;
    logic        ferr_q, ferr_d;
    logic [10:0] flen_q, flen_d;

    logic [pMII_WIDTH+7:0] sr_cat;
    logic [7:0]            sr_shift;
    logic [7:0]            evict;
    logic                  evict_vld;

    // New lane enters at the top so the oldest lane ends up in bit 0.
    assign sr_cat   = {Rxd, sr_q};
    assign sr_shift = 8'(sr_cat >> pMII_WIDTH);

    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        lane_d     = lane_q;
        crc_d      = crc_q;
        len_d      = len_q;
        er_d       = er_q;
        win_d      = win_q;
        win_cnt_d  = win_cnt_q;
        held_d     = held_q;
        held_vld_d = held_vld_q;
        bv_d       = 1'b0;
        byte_d     = 8'h00;
        last_d     = 1'b0;
        done_d     = 1'b0;
        crcv_d     = 1'b0;
        ferr_d     = 1'b0;
        flen_d     = 11'd0;
        evict      = 8'h00;
        evict_vld  = 1'b0;

        case (state_q)
            S_IDLE: begin
                sr_d   = 8'h00;
                lane_d = 2'd0;
                crc_d  = CRC_INIT;
                len_d  = 11'd0;
                er_d   = 1'b0;
                if (Rx_Dv) begin
                    state_d = S_PREAMBLE;
                end
            end
            S_PREAMBLE: begin
                sr_d = sr_shift;
                if (!Rx_Dv) begin
                    state_d = S_IDLE;
                end else if (sr_shift == 8'hD5) begin
                    state_d = S_DATA;
                    lane_d  = 2'd0;
                end
            end
            S_DATA: begin
                if (!Rx_Dv) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    flen_d  = len_q;
                    crcv_d  = (crc_q == CRC_RESIDUE);
                    ferr_d  = er_q || Rx_Er || (lane_q != 2'd0) ||
                              (int'(len_q) < pMIN_FRAME) || (int'(len_q) > pMAX_FRAME) ||
                              (crc_q != CRC_RESIDUE);
                    if (held_vld_q) begin
                        bv_d   = 1'b1;
                        byte_d = held_q;
                        last_d = 1'b1;
                    end
                    held_d     = 8'h00;
                    held_vld_d = 1'b0;
                    win_cnt_d  = 3'd0;
                    win_d      = '{default: 8'h00};
                end else begin
                    er_d = er_q | Rx_Er;
                    sr_d = sr_shift;
                    if (lane_q == LANE_LAST) begin
                        lane_d = 2'd0;
                        crc_d  = crc_byte(crc_q, sr_shift);
                        if (len_q != LEN_SAT) begin
                            len_d = len_q + 11'd1;
                        end
                        // The window delays output so the FCS never leaves the block.
                        if (pSTRIP_FCS != 0) begin
                            win_d     = '{win_q[1], win_q[2], win_q[3], sr_shift};
                            evict     = win_q[0];
                            evict_vld = (win_cnt_q == 3'd4);
                            if (win_cnt_q != 3'd4) begin
                                win_cnt_d = win_cnt_q + 3'd1;
                            end
                        end else begin
                            evict     = sr_shift;
                            evict_vld = 1'b1;
                        end
                        if (evict_vld) begin
                            if (held_vld_q) begin
                                bv_d   = 1'b1;
                                byte_d = held_q;
                            end
                            held_d     = evict;
                            held_vld_d = 1'b1;
                        end
                    end else begin
                        lane_d = lane_q + 2'd1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q    <= S_IDLE;
            sr_q       <= 8'h00;
            lane_q     <= 2'd0;
            crc_q      <= CRC_INIT;
            len_q      <= 11'd0;
            er_q       <= 1'b0;
            win_q      <= '{default: 8'h00};
            win_cnt_q  <= 3'd0;
            held_q     <= 8'h00;
            held_vld_q <= 1'b0;
            bv_q       <= 1'b0;
            byte_q     <= 8'h00;
            last_q     <= 1'b0;
            done_q     <= 1'b0;
            crcv_q     <= 1'b0;
            ferr_q     <= 1'b0;
            flen_q     <= 11'd0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            lane_q     <= lane_d;
            crc_q      <= crc_d;
            len_q      <= len_d;
            er_q       <= er_d;
            win_q      <= win_d;
            win_cnt_q  <= win_cnt_d;
            held_q     <= held_d;
            held_vld_q <= held_vld_d;
            bv_q       <= bv_d;
            byte_q     <= byte_d;
            last_q     <= last_d;
            done_q     <= done_d;
            crcv_q     <= crcv_d;
            ferr_q     <= ferr_d;
            flen_q     <= flen_d;
        end
    end

    assign Byte_Valid = bv_q;
    assign Byte       = byte_q;
    assign Byte_Last  = last_q;
    assign Frame_Done = done_q;
    assign Crc_Valid  = crcv_q;
    assign Frame_Err  = ferr_q;
    assign Frame_Len  = flen_q;
    assign Rx_Busy    = (state_q != S_IDLE);

endmodule
